memoria_dados_param: RTL
========================

Name: memoria_dados_param

Overview:
Parametrised successor to the processor's single-port data memory. It has configurable data and address widths and a pipelined synchronous read with configurable latency and a valid strobe. An optional hardware clear sequence zeroes the array after reset, and a busy/error indication covers requests made during the clear. It sits between the datapath (load/store stage) and the rest of the core, replacing the fixed 8-bit/256-entry data memory.

Parameters:
LARG_DADO, 8, data word width in bits
LARG_END, 8, address width in bits; depth = 2**LARG_END words
LATENCIA_LEITURA, 1, read latency in clock edges (legal 1..4)
LIMPA_NO_RESET, 1, 1 = zero every word after reset, 0 = contents undefined after reset and ready immediately

Ports:
Clock  input  1  system clock, all state updates on rising edge
ResetN  input  1  asynchronous active-low reset
LerMem  input  1  read request, sampled at rising edge
EscMem  input  1  write request, sampled at rising edge
Endereco  input  LARG_END  word address for read and/or write
DadoEscritoMem  input  LARG_DADO  write data
DadoLidoMem  output  LARG_DADO  read data, holds last returned value
DadoValido  output  1  one-cycle strobe: DadoLidoMem carries a new read result
Ocupado  output  1  high while the clear sequence runs; requests are not accepted
ErroAcesso  output  1  one-cycle pulse: a request arrived while Ocupado

Behaviour:
- Reset (ResetN=0, asynchronous):
  - DadoLidoMem=0, DadoValido=0, ErroAcesso=0.
  - Read pipeline flushed (all in-flight reads discarded).
  - Clear counter=0.
  - FSM enters LIMPANDO if LIMPA_NO_RESET=1 (Ocupado=1), else PRONTO (Ocupado=0).
  - Array contents are not touched asynchronously.
- FSM state LIMPANDO:
  - Each rising edge writes 0 to word[contador], then contador+1.
  - After writing word 2**LARG_END-1 (contador wraps to 0), go to PRONTO. Ocupado falls on that same edge.
  - Clear takes exactly 2**LARG_END cycles; default is 256.
- FSM state PRONTO: normal operation; stays in PRONTO until reset.
- Request while Ocupado:
  - The request is ignored: no write, no read issued.
  - ErroAcesso=1 for the cycle after that edge.
  - Back-to-back illegal requests give ErroAcesso continuously high.
- Write (PRONTO, EscMem=1): word[Endereco] <= DadoEscritoMem at the rising edge.
- Read (PRONTO, LerMem=1):
  - Address and data are sampled at edge k.
  - Result is presented after edge k+LATENCIA_LEITURA-1: DadoLidoMem updated and DadoValido=1 for exactly one cycle.
  - Latency 1 behaves as a registered read with no bubble.
- Pipelining:
  - One read may be issued per cycle.
  - N consecutive reads give N consecutive DadoValido cycles, in order.
  - DadoValido=0 in any cycle with no result; DadoLidoMem then holds its value.
- Simultaneous LerMem and EscMem, same address, same edge: read-before-write. The read returns the old word and the new word is stored.
- Read at edge k+1 after a write at edge k to the same address returns the new data.
- Address wrap: Endereco is exactly LARG_END bits, so no out-of-range case exists.
- Reset mid-clear: clear restarts from word 0.
- Reset mid-read: pending results are lost; no DadoValido after reset deassertion until a new read.
- Illegal LATENCIA_LEITURA (0 or >4): elaboration-time error.

Test Plan:
- Default params, release ResetN, hold LerMem=1 throughout the clear -> Ocupado=1 for exactly 256 cycles; ErroAcesso high for those 256 cycles; then reads of addr 0x00, 0x7F, 0xFF each return 0x00 with one DadoValido pulse.
- LATENCIA_LEITURA=3, write 0xA5@0x10 and 0x3C@0x11, then read 0x10, 0x11 on consecutive edges -> DadoValido high on edges k+2 and k+3 with data 0xA5 then 0x3C; DadoLidoMem holds 0x3C afterwards.
- Same edge LerMem=EscMem=1 at addr 0x20 (old 0x11, new 0x99) -> read returns 0x11; a following read returns 0x99.
- ResetN pulsed low at clear cycle 100 -> Ocupado stays 1 for a full 256 cycles after release; outputs are 0 during reset.
- LARG_DADO=16, LARG_END=4, LIMPA_NO_RESET=0 -> Ocupado=0 right after reset; write 0xBEEF@0xF, read back 0xBEEF; clear time not applied.
- Issue a read with LATENCIA_LEITURA=4, assert ResetN low 2 cycles later -> no DadoValido pulse ever appears for that read.

Source files
------------

// File: rtl/memoria_dados_param.sv
// Parametrised single-port data memory for the load/store stage: pipelined synchronous read
// with a valid strobe, and an optional post-reset sweep that zeroes every word.
//
// state    | meaning
// LIMPANDO | sweeping the array with zeros, requests rejected (Ocupado=1)
// PRONTO   | normal read/write service until the next reset
module memoria_dados_param #(
    parameter int LARG_DADO        = 8,
    parameter int LARG_END         = 8,
    parameter int LATENCIA_LEITURA = 1,
    parameter int LIMPA_NO_RESET   = 1
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 LerMem,
    input  logic                 EscMem,
    input  logic [LARG_END-1:0]  Endereco,
    input  logic [LARG_DADO-1:0] DadoEscritoMem,
    output logic [LARG_DADO-1:0] DadoLidoMem,
    output logic                 DadoValido,
    output logic                 Ocupado,
    output logic                 ErroAcesso
);

    localparam int PROF = 2 ** LARG_END;

    localparam logic [0:0] LIMPANDO = 1'b0;
    localparam logic [0:0] PRONTO   = 1'b1;

    generate
        if (LATENCIA_LEITURA < 1 || LATENCIA_LEITURA > 4) begin : g_latencia_invalida
            $error("memoria_dados_param: LATENCIA_LEITURA must be in 1..4");
        end
    endgenerate

    logic [LARG_DADO-1:0]        mem [PROF];
    logic [0:0]                  estado;
    logic [LARG_END-1:0]         contador;
    logic                        ler_ok;
    logic [LARG_DADO-1:0]        pipe_dado [LATENCIA_LEITURA];
    logic [LATENCIA_LEITURA-1:0] pipe_vld;

    assign Ocupado = (estado == LIMPANDO);
    assign ler_ok  = LerMem && !Ocupado;

    // No reset on the array; the sweep zeroes it synchronously instead.
    always_ff @(posedge Clock) begin
        if (Ocupado) begin
            mem[contador] <= '0;
        end else if (EscMem) begin
            mem[Endereco] <= DadoEscritoMem;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            estado     <= (LIMPA_NO_RESET != 0) ? LIMPANDO : PRONTO;
            contador   <= '0;
            ErroAcesso <= 1'b0;
        end else begin
            ErroAcesso <= Ocupado && (LerMem || EscMem);
            if (estado == LIMPANDO) begin
                contador <= contador + 1'b1;
                if (contador == {LARG_END{1'b1}}) begin
                    estado <= PRONTO;
                end
            end
        end
    end

    // Stage 0 reads the array before any same-edge write lands (read-before-write).
    // Each stage only loads data alongside a valid token, so the last stage holds
    // the most recent result between strobes.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCIA_LEITURA; i++) begin
                pipe_dado[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= ler_ok;
            if (ler_ok) begin
                pipe_dado[0] <= mem[Endereco];
            end
            for (int i = 1; i < LATENCIA_LEITURA; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dado[i] <= pipe_dado[i-1];
                end
            end
        end
    end

    assign DadoLidoMem = pipe_dado[LATENCIA_LEITURA-1];
    assign DadoValido  = pipe_vld[LATENCIA_LEITURA-1];

endmodule
